pipe_ctrl: RTL and testbench

Pipeline hazard and flow controller for the rv32 core: it sequences the pc, the IF/ID and ID/EX pipeline registers, and the ex stage's redirect. Three events drive it: taken jumps from ex, load-use hazards between id and ex, and data-memory busy holds. It sits beside the pc/ifu/id/regs/ex datapath and owns every stall, bubble and flush control in the pipeline. It also keeps two cycle counters for performance bring-up.

---
 rtl/pipe_ctrl_if.sv | 51 +++++
 rtl/pipe_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Bundles the hazard/flow signals that run between the rv32
//               datapath and pipe_ctrl. The datapath side holds the master
//               modport and pipe_ctrl holds the slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_ctrl_if #(
    parameter int XLEN = 32
);
    // Events presented by the datapath
    logic            ex_jump;
    logic [XLEN-1:0] ex_jump_addr;
    logic            ex_mem_read_en;
    logic [4:0]      ex_rd;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic            id_rs1_en;
    logic            id_rs2_en;
    logic            mem_busy;

    // Controls returned to the datapath
    logic            pc_jump;
    logic [XLEN-1:0] pc_jump_addr;
    logic            pc_pause;
    logic            if_id_hold;
    logic            id_ex_hold;
    logic            if_id_flush;
    logic            id_ex_flush;
    logic [1:0]      state;
    logic [31:0]     stall_cnt;
    logic [31:0]     flush_cnt;

    modport master (
        output ex_jump, ex_jump_addr, ex_mem_read_en, ex_rd,
               id_rs1, id_rs2, id_rs1_en, id_rs2_en, mem_busy,
        input  pc_jump, pc_jump_addr, pc_pause, if_id_hold, id_ex_hold,
               if_id_flush, id_ex_flush, state, stall_cnt, flush_cnt
    );

    modport slave (
        input  ex_jump, ex_jump_addr, ex_mem_read_en, ex_rd,
               id_rs1, id_rs2, id_rs1_en, id_rs2_en, mem_busy,
        output pc_jump, pc_jump_addr, pc_pause, if_id_hold, id_ex_hold,
               if_id_flush, id_ex_flush, state, stall_cnt, flush_cnt
    );
endinterface

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline hazard and flow controller for the rv32 core. Owns
//               pc pause/redirect, IF/ID and ID/EX hold and flush, and keeps
//               stall/flush cycle counters. Outputs are Mealy (state plus the
//               current cycle's inputs); priority is mem_busy > ex_jump >
//               load-use hazard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2      // legal range 1..7
) (
    input  wire logic       clk,
    input  wire logic       rst,
    pipe_ctrl_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2,
        ST_HOLD       = 2'd3
    } state_t;

    // The jump cycle itself is the first flush cycle, so FLUSH covers the rest.
    localparam logic [2:0] C_FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
    localparam bit         C_HAS_FLUSH  = (FLUSH_CYCLES > 1);

    state_t          r_state;
    state_t          w_next_state;
    logic [2:0]      r_fcnt;
    logic [2:0]      w_next_fcnt;
    logic [31:0]     r_stall_cnt;
    logic [31:0]     r_flush_cnt;

    logic            w_hazard;
    logic            w_stall_inc;
    logic            w_flush_inc;
    logic            w_pc_jump;
    logic [XLEN-1:0] w_pc_jump_addr;
    logic            w_pc_pause;
    logic            w_if_id_hold;
    logic            w_id_ex_hold;
    logic            w_if_id_flush;
    logic            w_id_ex_flush;

    // Load-use hazard: a load in ex writes a register the id instruction reads.
    always_comb begin
        w_hazard = bus.ex_mem_read_en && (bus.ex_rd != 5'd0) &&
                   ((bus.id_rs1_en && (bus.id_rs1 == bus.ex_rd)) ||
                    (bus.id_rs2_en && (bus.id_rs2 == bus.ex_rd)));
    end

    // Next-state and Mealy output decode; reset forces every output low at once.
    always_comb begin
        w_next_state   = r_state;
        w_next_fcnt    = r_fcnt;
        w_stall_inc    = 1'b0;
        w_flush_inc    = 1'b0;
        w_pc_jump      = 1'b0;
        w_pc_jump_addr = '0;
        w_pc_pause     = 1'b0;
        w_if_id_hold   = 1'b0;
        w_id_ex_hold   = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;

        if (!rst) begin
            case (r_state)
                ST_FLUSH: begin
                    // ex holds a bubble here, so busy and jump are both ignored.
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                    if (r_fcnt <= 3'd1) begin
                        w_next_state = ST_RUN;
                        w_next_fcnt  = 3'd0;
                    end else begin
                        w_next_fcnt  = r_fcnt - 3'd1;
                    end
                end
                default: begin
                    // RUN, LOAD_STALL and HOLD share the event priority chain;
                    // a jump seen while busy is re-presented once busy drops.
                    if (bus.mem_busy) begin
                        w_pc_pause   = 1'b1;
                        w_if_id_hold = 1'b1;
                        w_id_ex_hold = 1'b1;
                        w_stall_inc  = 1'b1;
                        w_next_state = ST_HOLD;
                    end else if (bus.ex_jump) begin
                        w_pc_jump      = 1'b1;
                        w_pc_jump_addr = bus.ex_jump_addr;
                        w_if_id_flush  = 1'b1;
                        w_id_ex_flush  = 1'b1;
                        w_flush_inc    = 1'b1;
                        if (C_HAS_FLUSH) begin
                            w_next_state = ST_FLUSH;
                            w_next_fcnt  = C_FLUSH_INIT;
                        end else begin
                            w_next_state = ST_RUN;
                        end
                    end else if (w_hazard && (r_state != ST_LOAD_STALL)) begin
                        // One bubble into ex while pc and IF/ID wait for the load.
                        w_pc_pause    = 1'b1;
                        w_if_id_hold  = 1'b1;
                        w_id_ex_flush = 1'b1;
                        w_stall_inc   = 1'b1;
                        w_next_state  = ST_LOAD_STALL;
                    end else begin
                        w_next_state = ST_RUN;
                    end
                end
            endcase
        end
    end

    // State, flush counter and performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_fcnt      <= 3'd0;
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            r_state <= w_next_state;
            r_fcnt  <= w_next_fcnt;
            if (w_stall_inc) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_flush_inc) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign bus.pc_jump      = w_pc_jump;
    assign bus.pc_jump_addr = w_pc_jump_addr;
    assign bus.pc_pause     = w_pc_pause;
    assign bus.if_id_hold   = w_if_id_hold;
    assign bus.id_ex_hold   = w_id_ex_hold;
    assign bus.if_id_flush  = w_if_id_flush;
    assign bus.id_ex_flush  = w_id_ex_flush;
    assign bus.state        = r_state;
    assign bus.stall_cnt    = r_stall_cnt;
    assign bus.flush_cnt    = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Directed self-checking bench for pipe_ctrl (FLUSH_CYCLES=2).
//               Inputs change on the falling edge; outputs are sampled 1 time
//               unit later, well away from the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.XLEN(32)) bus ();

    pipe_ctrl #(
        .XLEN         (32),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Output vector {pc_jump, pc_pause, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush}
    localparam logic [31:0] C_NONE  = 32'b000000;
    localparam logic [31:0] C_LDUSE = 32'b011001;
    localparam logic [31:0] C_JUMP  = 32'b100011;
    localparam logic [31:0] C_FLUSH = 32'b000011;
    localparam logic [31:0] C_HOLD  = 32'b011100;

    function automatic logic [31:0] outs();
        return 32'({bus.pc_jump, bus.pc_pause, bus.if_id_hold, bus.id_ex_hold,
                    bus.if_id_flush, bus.id_ex_flush});
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic jump, input logic [31:0] addr, input logic busy,
                         input logic mr, input logic [4:0] rd,
                         input logic [4:0] rs2, input logic rs2_en);
        bus.ex_jump        = jump;
        bus.ex_jump_addr   = addr;
        bus.mem_busy       = busy;
        bus.ex_mem_read_en = mr;
        bus.ex_rd          = rd;
        bus.id_rs1         = 5'd0;
        bus.id_rs1_en      = 1'b0;
        bus.id_rs2         = rs2;
        bus.id_rs2_en      = rs2_en;
    endtask

    // Advance to the next falling edge, apply inputs, let outputs settle.
    task automatic step(input logic jump, input logic [31:0] addr, input logic busy,
                        input logic mr, input logic [4:0] rd,
                        input logic [4:0] rs2, input logic rs2_en);
        @(negedge clk);
        drive(jump, addr, busy, mr, rd, rs2, rs2_en);
        #1;
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        #1;
        // Reset state
        check("rst_outs",  outs(), C_NONE);
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_stall", bus.stall_cnt, 32'd0);
        check("rst_flush", bus.flush_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Load-use on rs2: one bubble, then hazard masked in LOAD_STALL
        step(1'b0, 32'h0, 1'b0, 1'b1, 5'd5, 5'd5, 1'b1);
        check("lu_outs",  outs(), C_LDUSE);
        check("lu_state", 32'(bus.state), 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 5'd5, 5'd5, 1'b1);
        check("lu_stall_state", 32'(bus.state), 32'd1);
        check("lu_stall_outs",  outs(), C_NONE);
        check("lu_stall_cnt",   bus.stall_cnt, 32'd1);
        // Same pattern with ex_rd=0 is not a hazard
        step(1'b0, 32'h0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1);
        check("rd0_state", 32'(bus.state), 32'd0);
        check("rd0_outs",  outs(), C_NONE);
        step(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        check("rd0_stall_cnt", bus.stall_cnt, 32'd1);

        // Jump: redirect for one cycle, flush for two, second jump ignored
        step(1'b1, 32'h40, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        check("jmp_outs", outs(), C_JUMP);
        check("jmp_addr", bus.pc_jump_addr, 32'h40);
        step(1'b1, 32'h80, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        check("jmp_fl_state", 32'(bus.state), 32'd2);
        check("jmp_fl_outs",  outs(), C_FLUSH);
        check("jmp_fl_addr",  bus.pc_jump_addr, 32'h0);
        check("jmp_fl_cnt",   bus.flush_cnt, 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        check("jmp_end_state", 32'(bus.state), 32'd0);
        check("jmp_end_outs",  outs(), C_NONE);

        // Jump under mem_busy for 3 cycles: deferred until busy drops
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h100, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
            check("jb_hold_outs",  outs(), C_HOLD);
            check("jb_hold_addr",  bus.pc_jump_addr, 32'h0);
            check("jb_hold_state", 32'(bus.state), (i == 0) ? 32'd0 : 32'd3);
        end
        step(1'b1, 32'h100, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        check("jb_rel_state", 32'(bus.state), 32'd3);
        check("jb_rel_outs",  outs(), C_JUMP);
        check("jb_rel_addr",  bus.pc_jump_addr, 32'h100);
        check("jb_stall_cnt", bus.stall_cnt, 32'd4);
        step(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        check("jb_fl_outs",  outs(), C_FLUSH);
        check("jb_flush_cnt", bus.flush_cnt, 32'd2);
        step(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        check("jb_end_state", 32'(bus.state), 32'd0);

        // Jump and hazard together: jump path only
        step(1'b1, 32'h200, 1'b0, 1'b1, 5'd7, 5'd7, 1'b1);
        check("jh_outs", outs(), C_JUMP);
        check("jh_addr", bus.pc_jump_addr, 32'h200);
        step(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        check("jh_state",     32'(bus.state), 32'd2);
        check("jh_stall_cnt", bus.stall_cnt, 32'd4);
        check("jh_flush_cnt", bus.flush_cnt, 32'd3);

        // Asynchronous reset mid-FLUSH, between edges
        #2;
        rst = 1'b1;
        #1;
        check("ar_outs",  outs(), C_NONE);
        check("ar_state", 32'(bus.state), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ar_stall_cnt", bus.stall_cnt, 32'd0);
        check("ar_flush_cnt", bus.flush_cnt, 32'd0);
        check("ar_rel_state", 32'(bus.state), 32'd0);

        // Stall counter wraps from all-ones to zero
        #1;
        force dut.r_stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_stall_cnt;
        #1;
        check("wrap_pre", bus.stall_cnt, 32'hFFFF_FFFF);
        step(1'b0, 32'h0, 1'b0, 1'b1, 5'd9, 5'd9, 1'b1);
        check("wrap_outs", outs(), C_LDUSE);
        step(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        check("wrap_cnt", bus.stall_cnt, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
